// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Purpose  : 8-bit UART receiver for host command bytes. The line idles high.
//            Each bit is split into 16 oversample ticks. The bit value is the
//            majority of the samples taken at ticks 7, 8 and 9. Received
//            bytes go into a small first-word-fall-through FIFO that the
//            consumer drains over a valid/ready handshake.
//
// Ports    : clk        in   system clock
//            rstn       in   synchronous active-low reset
//            uart_rxd   in   asynchronous serial input, idle high
//            rx_data    out  FIFO head byte, 0x00 while the FIFO is empty
//            rx_valid   out  FIFO not empty
//            rx_ready   in   consumer accept; a pop is rx_valid & rx_ready
//            frame_err  out  one-cycle pulse when the stop bit is sampled low
//            parity_err out  one-cycle pulse on parity mismatch (0 w/o macro)
//            ovf_err    out  sticky; a good byte was dropped on a full FIFO
//            clr_err    in   clears ovf_err (a new overflow takes priority)
//            busy       out  receiver is not idle
//
// Options  : `define UART_RX_PARITY_EN adds an even-parity bit after the data
//            bits (8E1, 11-bit frames). Without it, frames are 8N1.
//
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int CLKS_PER_TICK = 27,   // 2..4095, 16 ticks per bit
    parameter int FIFO_DEPTH    = 4     // power of two, 2..16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       ovf_err,
    input  logic       clr_err,
    output logic       busy
);

    localparam int          c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [11:0] c_TICK_LAST = 12'(CLKS_PER_TICK - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------------
    // Input synchronizer. Both flops reset to the idle level so that reset
    // never looks like a start edge.
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rxd_s;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s = r_sync2;

    // ------------------------------------------------------------------------
    // Receive state and bit timing
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_armed;
    logic [11:0] r_presc;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_samp7;
    logic        r_samp8;
    logic [7:0]  r_shreg;
    logic        r_frame_err;
    logic        r_parity_err;

    logic w_tick;
    logic w_decide;
    logic w_bit_end;
    logic w_maj;
    logic w_stop_dec;
    logic w_parity_bad;
    logic w_push;

    assign w_tick    = (r_presc == c_TICK_LAST);
    // The decision cycle is the last clock of tick 9; the bit ends on the
    // last clock of tick 15.
    assign w_decide  = w_tick && (r_tick_cnt == 4'd9);
    assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);
    // The tick-9 sample is the live synchronized value in the decision cycle.
    assign w_maj     = (r_samp7 & r_samp8) | (r_samp7 & w_rxd_s) | (r_samp8 & w_rxd_s);

    assign w_stop_dec = (r_state == c_ST_STOP) && w_decide;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_parity_bad = ^{r_shreg, r_par_bit};
`else
    assign w_parity_bad = 1'b0;
`endif

    assign w_push = w_stop_dec && w_maj && !w_parity_bad;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_rxd_s && r_armed) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                // A start bit that reads high at mid-bit was a glitch.
                if (w_decide && w_maj) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = c_ST_PARITY;
`else
                    w_state_nxt = c_ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = c_ST_STOP;
                end
            end
`endif
            c_ST_STOP: begin
                // Return at mid-stop so that a start edge can follow at once.
                if (w_decide) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_armed      <= 1'b0;
            r_presc      <= 12'd0;
            r_tick_cnt   <= 4'd0;
            r_bit_idx    <= 3'd0;
            r_samp7      <= 1'b1;
            r_samp8      <= 1'b1;
            r_shreg      <= 8'h00;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            // Timing counters are held at zero while idle, so they start from
            // zero on entry to START.
            if (r_state == c_ST_IDLE) begin
                r_presc    <= 12'd0;
                r_tick_cnt <= 4'd0;
                r_bit_idx  <= 3'd0;
            end else begin
                if (w_tick) begin
                    r_presc    <= 12'd0;
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                end else begin
                    r_presc <= r_presc + 12'd1;
                end
                if (w_tick && (r_tick_cnt == 4'd7)) begin
                    r_samp7 <= w_rxd_s;
                end
                if (w_tick && (r_tick_cnt == 4'd8)) begin
                    r_samp8 <= w_rxd_s;
                end
                if ((r_state == c_ST_DATA) && w_decide) begin
                    r_shreg <= {w_maj, r_shreg[7:1]};
                end
                if ((r_state == c_ST_DATA) && w_bit_end) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end

            // Re-arming needs the line to be seen high in IDLE, so a held-low
            // line (break) after a frame cannot start a new one.
            if ((r_state == c_ST_IDLE) && w_rxd_s) begin
                r_armed <= 1'b1;
            end else if (w_stop_dec) begin
                r_armed <= 1'b0;
            end

            r_frame_err  <= w_stop_dec && !w_maj;
            r_parity_err <= w_stop_dec && w_maj && w_parity_bad;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_par_bit <= 1'b0;
        end else if ((r_state == c_ST_PARITY) && w_decide) begin
            r_par_bit <= w_maj;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = r_frame_err;
    assign busy      = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------------
    // Output FIFO. Pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          r_ovf_err;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_do_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= r_shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf_err <= 1'b1;
            end else if (clr_err) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    assign rx_valid = !w_empty;
    // Storage is not reset; masking keeps rx_data at 0x00 when empty.
    assign rx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign ovf_err  = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_cmd_rx
// Purpose  : Directed self-checking bench for uart_cmd_rx with
//            CLKS_PER_TICK=4 (64 clocks per bit) and FIFO_DEPTH=4. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int CPT   = 4;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       ovf_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int n_ferr   = 0;
    int n_perr   = 0;
    int e_ferr;
    int e_perr;

    logic [7:0] b2b [4] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    logic [7:0] ovb [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] ovx [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    logic [7:0] c3;
    logic [7:0] bad81;

    uart_cmd_rx #(
        .CLKS_PER_TICK (CPT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .ovf_err    (ovf_err),
        .clr_err    (clr_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Error-pulse counters, used to prove that no unexpected pulse occurred.
    always @(posedge clk) begin
        if (frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (parity_err === 1'b1) n_perr = n_perr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame, 64 clocks per bit. The stop bit is held for stop_hold
    // falling edges before returning; the line is left at the stop level.
    // With stop_hold=42 the return point lies just before the clock edge that
    // ends the stop decision cycle.
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp, input int stop_hold);
        @(negedge clk) uart_rxd = 1'b0;
        repeat (63) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) uart_rxd = d[i];
            repeat (63) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        @(negedge clk) uart_rxd = par;
        repeat (63) @(negedge clk);
`else
        if (par === 1'bx) uart_rxd = 1'bx;  // parity bit absent in 8N1 frames
`endif
        @(negedge clk) uart_rxd = stp;
        repeat (stop_hold) @(negedge clk);
    endtask

    initial begin
        // ---------------- reset values ----------------
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data",  rx_data,    8'h00);
        check("rst_rx_valid", rx_valid,   1'b0);
        check("rst_frame",    frame_err,  1'b0);
        check("rst_parity",   parity_err, 1'b0);
        check("rst_ovf",      ovf_err,    1'b0);
        check("rst_busy",     busy,       1'b0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        // ---------------- single byte, exact push latency ----------------
        rx_ready = 1'b1;
        send_frame(8'h55, ^8'h55, 1'b1, 42);
        check("single_not_yet", rx_valid, 1'b0);
        @(negedge clk);
        check("single_valid", rx_valid,  1'b1);
        check("single_data",  rx_data,   8'h55);
        check("single_ferr",  frame_err, 1'b0);
        @(negedge clk);
        check("single_popped", rx_valid, 1'b0);
        check("single_no_err", n_ferr + n_perr, 0);
        repeat (30) @(negedge clk);

        // ---------------- back-to-back into the FIFO ----------------
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(b2b[i], ^b2b[i], 1'b1, 64);
        repeat (10) @(negedge clk);
        check("b2b_valid", rx_valid, 1'b1);
        check("b2b_head",  rx_data,  8'hA5);
        repeat (20) @(negedge clk);
        check("b2b_hold",  rx_data,  8'hA5);
        for (int i = 0; i < 4; i++) begin
            check("b2b_order", rx_data, b2b[i]);
            rx_ready = 1'b1;
            @(negedge clk) rx_ready = 1'b0;
        end
        check("b2b_empty", rx_valid, 1'b0);

        // ---------------- glitch on idle line ----------------
        e_ferr = n_ferr;
        @(negedge clk) uart_rxd = 1'b0;
        repeat (16) @(negedge clk);
        uart_rxd = 1'b1;
        check("glitch_busy", busy, 1'b1);
        repeat (80) @(negedge clk);
        check("glitch_idle",  busy,     1'b0);
        check("glitch_nopush", rx_valid, 1'b0);
        check("glitch_noerr", n_ferr,   e_ferr);

        // ---------------- framing error then break ----------------
        bad81 = 8'h81;
        send_frame(bad81, ^bad81, 1'b0, 42);
        @(negedge clk);
        check("frame_pulse",  frame_err, 1'b1);
        check("frame_nopush", rx_valid,  1'b0);
        @(negedge clk);
        check("frame_onecyc", frame_err, 1'b0);
        repeat (1000) @(negedge clk);
        check("break_idle",   busy,     1'b0);
        check("break_nopush", rx_valid, 1'b0);
        check("break_count",  n_ferr,   e_ferr + 1);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);

        // ---------------- overflow, clear, full push+pop ----------------
        for (int i = 0; i < 5; i++) send_frame(ovb[i], ^ovb[i], 1'b1, 64);
        repeat (10) @(negedge clk);
        check("ovf_set",   ovf_err,  1'b1);
        check("ovf_valid", rx_valid, 1'b1);
        check("ovf_head",  rx_data,  8'h11);
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        check("ovf_clear", ovf_err, 1'b0);
        send_frame(8'h66, ^8'h66, 1'b1, 42);
        rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
        check("full_pushpop_ovf", ovf_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("full_order", rx_data, ovx[i]);
            rx_ready = 1'b1;
            @(negedge clk) rx_ready = 1'b0;
        end
        check("full_drained", rx_valid, 1'b0);

        // ---------------- reset mid-frame ----------------
        send_frame(8'h77, ^8'h77, 1'b1, 64);
        check("pre_rst_valid", rx_valid, 1'b1);
        e_ferr = n_ferr;
        c3 = 8'hC3;
        @(negedge clk) uart_rxd = 1'b0;
        repeat (63) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) uart_rxd = c3[i];
            repeat (63) @(negedge clk);
        end
        @(negedge clk) uart_rxd = c3[4];
        repeat (31) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        uart_rxd = 1'b1;
        check("mrst_rx_data",  rx_data,    8'h00);
        check("mrst_rx_valid", rx_valid,   1'b0);
        check("mrst_frame",    frame_err,  1'b0);
        check("mrst_parity",   parity_err, 1'b0);
        check("mrst_busy",     busy,       1'b0);
        repeat (200) @(negedge clk);
        check("mrst_nopush", rx_valid, 1'b0);
        check("mrst_noerr",  n_ferr,   e_ferr);
        rx_ready = 1'b1;
        send_frame(8'h12, ^8'h12, 1'b1, 42);
        check("after_rst_not_yet", rx_valid, 1'b0);
        @(negedge clk);
        check("after_rst_valid", rx_valid, 1'b1);
        check("after_rst_data",  rx_data,  8'h12);
        @(negedge clk);
        check("after_rst_popped", rx_valid, 1'b0);
        repeat (30) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        send_frame(8'h07, 1'b1, 1'b1, 42);
        @(negedge clk);
        check("par_good_valid", rx_valid, 1'b1);
        check("par_good_data",  rx_data,  8'h07);
        @(negedge clk);
        repeat (30) @(negedge clk);
        e_perr = n_perr;
        send_frame(8'h07, 1'b0, 1'b1, 42);
        @(negedge clk);
        check("par_bad_pulse",  parity_err, 1'b1);
        check("par_bad_nopush", rx_valid,   1'b0);
        @(negedge clk);
        check("par_bad_onecyc", parity_err, 1'b0);
        check("par_bad_count",  n_perr,     e_perr + 1);
        repeat (30) @(negedge clk);
`else
        e_perr = 0;
        check("no_parity_pulses", n_perr, e_perr);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
